// File: rtl/axi_pkg.sv
// Shared AXI-lite constants, response codes and FSM state types for the SRAM responder.
package axi_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RIdle,
    RWait,
    RResp
  } rd_state_e;

  typedef enum logic [1:0] {
    WIdle,
    WWait,
    WResp
  } wr_state_e;

endpackage

// File: rtl/axi_lite_sram_if.sv
// AXI-lite bus bundle between the fetch/LSU arbiter (master) and the SRAM responder (slave).
interface axi_lite_sram_if;
  import axi_pkg::*;

  logic [AddrWidth-1:0] araddr;
  logic                 arvalid;
  logic                 arready;
  logic [DataWidth-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;
  logic [AddrWidth-1:0] awaddr;
  logic                 awvalid;
  logic                 awready;
  logic [DataWidth-1:0] wdata;
  logic [StrbWidth-1:0] wstrb;
  logic                 wvalid;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/sram_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), loads seed on reset, advances when enabled.
module sram_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] state;
  logic       fb;

  assign fb = state[7] ^ state[5] ^ state[4] ^ state[3];
  assign q  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= seed;
    end else if (en) begin
      state <= {state[6:0], fb};
    end
  end

endmodule

// File: rtl/axi_lite_sram.sv
// AXI-lite SRAM responder with independent read/write FSMs and configurable response latency.
// Define SRAM_RAND_DELAY_EN to add 0-7 LFSR-driven extra cycles per transaction.
module axi_lite_sram
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned WR_LATENCY  = 1
) (
  input logic            clk,
  input logic            rst,
  axi_lite_sram_if.slave bus
);

  localparam int unsigned IdxW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WinEnd = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [31:0] RdLoad = 32'(RD_LATENCY - 1);
  localparam logic [31:0] WrLoad = 32'(WR_LATENCY - 1);

  logic [31:0] mem [DEPTH_WORDS];

  // 33-bit compare so a window touching the top of the address space cannot wrap
  function automatic logic in_range(input logic [31:0] addr);
    return ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < WinEnd);
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return off[IdxW+1:2];
  endfunction

  logic [2:0]  rd_extra;
  logic [2:0]  wr_extra;
  logic [31:0] rd_load;
  logic [31:0] wr_load;

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  sram_lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .seed (8'hA5),
    .q    (lfsr)
  );

  assign rd_extra = lfsr[2:0];
  assign wr_extra = lfsr[5:3];
`else
  assign rd_extra = 3'd0;
  assign wr_extra = 3'd0;
`endif

  assign rd_load = RdLoad + 32'(rd_extra);
  assign wr_load = WrLoad + 32'(wr_extra);

  // ---------------- read path ----------------
  rd_state_e   rd_state;
  logic [31:0] rd_cnt;
  logic [31:0] rd_addr;
  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [31:0] rd_src_addr;
  logic        rd_hit;

  // Shortcut path latches straight from the bus; the wait path uses the captured address
  assign rd_src_addr = (rd_state == RIdle) ? bus.araddr : rd_addr;
  assign rd_hit      = in_range(rd_src_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state  <= RIdle;
      rd_cnt    <= '0;
      rd_addr   <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rd_state)
        RIdle: begin
          if (bus.arvalid && arready_q) begin
            rd_addr   <= bus.araddr;
            arready_q <= 1'b0;
            if (rd_load == '0) begin
              rd_state <= RResp;
              rvalid_q <= 1'b1;
              rdata_q  <= rd_hit ? mem[word_idx(rd_src_addr)] : '0;
              rresp_q  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end else begin
              rd_cnt   <= rd_load;
              rd_state <= RWait;
            end
          end
        end
        RWait: begin
          rd_cnt <= rd_cnt - 32'd1;
          if (rd_cnt == 32'd1) begin
            rd_state <= RResp;
            rvalid_q <= 1'b1;
            rdata_q  <= rd_hit ? mem[word_idx(rd_src_addr)] : '0;
            rresp_q  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
          end
        end
        RResp: begin
          if (bus.rready) begin
            rd_state  <= RIdle;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: rd_state <= RIdle;
      endcase
    end
  end

  // ---------------- write path ----------------
  wr_state_e   wr_state;
  logic [31:0] wr_cnt;
  logic        aw_done;
  logic        w_done;
  logic        awready_q;
  logic        wready_q;
  logic [31:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;

  logic        aw_hs;
  logic        w_hs;
  logic        both_have;
  logic [31:0] wc_addr;
  logic [31:0] wc_data;
  logic [3:0]  wc_strb;
  logic [1:0]  wc_resp;
  logic        wr_commit;

  assign aw_hs     = bus.awvalid && awready_q;
  assign w_hs      = bus.wvalid && wready_q;
  assign both_have = (aw_done || aw_hs) && (w_done || w_hs);
  assign wc_addr   = aw_done ? awaddr_q : bus.awaddr;
  assign wc_data   = w_done ? wdata_q : bus.wdata;
  assign wc_strb   = w_done ? wstrb_q : bus.wstrb;
  assign wc_resp   = in_range(wc_addr) ? RESP_OKAY : RESP_SLVERR;

  always_comb begin
    wr_commit = 1'b0;
    case (wr_state)
      WIdle:   wr_commit = both_have && (wr_load == '0);
      WWait:   wr_commit = (wr_cnt == 32'd1);
      default: wr_commit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state  <= WIdle;
      wr_cnt    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (wr_state)
        WIdle: begin
          if (aw_hs) begin
            awaddr_q  <= bus.awaddr;
            aw_done   <= 1'b1;
            awready_q <= 1'b0;
          end
          if (w_hs) begin
            wdata_q  <= bus.wdata;
            wstrb_q  <= bus.wstrb;
            w_done   <= 1'b1;
            wready_q <= 1'b0;
          end
          if (both_have) begin
            if (wr_load == '0) begin
              wr_state <= WResp;
              bvalid_q <= 1'b1;
              bresp_q  <= wc_resp;
            end else begin
              wr_cnt   <= wr_load;
              wr_state <= WWait;
            end
          end
        end
        WWait: begin
          wr_cnt <= wr_cnt - 32'd1;
          if (wr_cnt == 32'd1) begin
            wr_state <= WResp;
            bvalid_q <= 1'b1;
            bresp_q  <= wc_resp;
          end
        end
        WResp: begin
          if (bus.bready) begin
            wr_state  <= WIdle;
            bvalid_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: wr_state <= WIdle;
      endcase
    end
  end

  // Memory is not reset; an aborted write never reaches its commit edge
  always_ff @(posedge clk) begin
    if (!rst && wr_commit && in_range(wc_addr)) begin
      for (int i = 0; i < 4; i++) begin
        if (wc_strb[i]) begin
          mem[word_idx(wc_addr)][8*i +: 8] <= wc_data[8*i +: 8];
        end
      end
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram: scoreboard queues of expected R/B results vs a memory model.
module tb_axi_lite_sram;
  import axi_pkg::*;

  localparam logic [31:0] Base   = 32'h8000_0000;
  localparam int          Depth  = 1024;
  localparam int          RdLat  = 1;
  localparam int          WrLat  = 3;
`ifdef SRAM_RAND_DELAY_EN
  localparam int          RandMax = 7;
`else
  localparam int          RandMax = 0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_sram_if bus ();

  axi_lite_sram #(
    .BASE_ADDR   (Base),
    .DEPTH_WORDS (Depth),
    .RD_LATENCY  (RdLat),
    .WR_LATENCY  (WrLat)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          tot = 0;
  int          bad = 0;
  logic [31:0] ref_mem [int];
  rexp_t       rq [$];
  logic [1:0]  bq [$];

  function automatic bit model_in_range(input logic [31:0] a);
    longint la;
    la = longint'({32'b0, a});
    return (la >= longint'({32'b0, Base})) && (la < longint'({32'b0, Base}) + 4 * Depth);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int idx;
    if (!model_in_range(a)) return 32'h0;
    idx = int'((a - Base) >> 2);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'hxxxx_xxxx;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    int          idx;
    logic [31:0] w;
    if (!model_in_range(a)) return;
    idx = int'((a - Base) >> 2);
    w   = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    ref_mem[idx] = w;
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a);
    return model_in_range(a) ? RESP_OKAY : RESP_SLVERR;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives one read; returns observed data/resp and latency (-1 on timeout)
  task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int n;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin cyc(); n++; end
    cyc();
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 50) begin cyc(); n++; end
    lat  = bus.rvalid ? n + 1 : -1;
    data = bus.rdata;
    resp = bus.rresp;
    if (bus.rready) cyc();
  endtask

  // Drives AW and W together; returns observed bresp and latency (-1 on timeout)
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    int n;
    bus.awaddr  = a;
    bus.awvalid = 1'b1;
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.wvalid  = 1'b1;
    n = 0;
    while (!(bus.awready && bus.wready) && n < 50) begin cyc(); n++; end
    cyc();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 50) begin cyc(); n++; end
    lat  = bus.bvalid ? n + 1 : -1;
    resp = bus.bresp;
    if (bus.bready) cyc();
  endtask

  task automatic test_reset();
    logic [40:0] obs;
    repeat (2) cyc();
    obs = {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid,
           bus.rdata, bus.rresp, bus.bresp};
    tot++;
    if (obs !== {5'b11100, 32'h0, 2'b00, 2'b00}) begin
      bad++;
      $display("FAIL reset_outputs: got %h want %h", obs, {5'b11100, 36'h0});
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_write_read();
    logic [31:0] addrs [3] = '{32'h8000_0010, 32'h8000_0000, 32'h8000_0020};
    logic [31:0] vals  [3] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h1122_3344};
    logic [31:0] data;
    logic [1:0]  resp, eb;
    int          lat;
    rexp_t       e;
    for (int i = 0; i < 3; i++) begin
      bq.push_back(model_resp(addrs[i]));
      model_write(addrs[i], vals[i], 4'hF);
      do_write(addrs[i], vals[i], 4'hF, resp, lat);
      eb = bq.pop_front();
      tot++;
      if (resp !== eb) begin bad++; $display("FAIL wr_bresp[%0d]: got %h want %h", i, resp, eb); end
      tot++;
      if (lat < WrLat || lat > WrLat + RandMax) begin
        bad++; $display("FAIL wr_latency[%0d]: got %0d want %0d..%0d", i, lat, WrLat, WrLat + RandMax);
      end
    end
    rq.push_back('{data: model_read(addrs[0]), resp: model_resp(addrs[0])});
    do_read(addrs[0], data, resp, lat);
    e = rq.pop_front();
    tot++;
    if ({data, resp} !== {e.data, e.resp}) begin
      bad++; $display("FAIL rd_after_wr: got %h/%h want %h/%h", data, resp, e.data, e.resp);
    end
    tot++;
    if (lat < RdLat || lat > RdLat + RandMax) begin
      bad++; $display("FAIL rd_latency: got %0d want %0d..%0d", lat, RdLat, RdLat + RandMax);
    end
  endtask

  task automatic test_strobes();
    logic [31:0] data;
    logic [1:0]  resp, eb;
    int          lat;
    rexp_t       e;
    bq.push_back(model_resp(32'h8000_0020));
    model_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101);
    do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, resp, lat);
    eb = bq.pop_front();
    tot++;
    if (resp !== eb) begin bad++; $display("FAIL strb_bresp: got %h want %h", resp, eb); end
    rq.push_back('{data: 32'h11BB_33DD, resp: RESP_OKAY});
    do_read(32'h8000_0020, data, resp, lat);
    e = rq.pop_front();
    tot++;
    if ({data, resp} !== {e.data, e.resp}) begin
      bad++; $display("FAIL strb_read: got %h/%h want %h/%h", data, resp, e.data, e.resp);
    end
  endtask

  task automatic test_decoupled();
    logic [31:0] data;
    logic [1:0]  resp, eb;
    int          n, lat;
    rexp_t       e;
    bus.wdata  = 32'hCAFE_F00D;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    bq.push_back(model_resp(32'h8000_0030));
    model_write(32'h8000_0030, 32'hCAFE_F00D, 4'hF);
    cyc();
    bus.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tot++;
      if ({bus.wready, bus.awready, bus.bvalid} !== 3'b010) begin
        bad++;
        $display("FAIL w_first_ready[%0d]: got wready/awready/bvalid=%b want 010", i,
                 {bus.wready, bus.awready, bus.bvalid});
      end
      if (i < 2) cyc();
    end
    bus.awaddr  = 32'h8000_0030;
    bus.awvalid = 1'b1;
    cyc();
    bus.awvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 50) begin cyc(); n++; end
    lat = bus.bvalid ? n + 1 : -1;
    eb  = bq.pop_front();
    tot++;
    if (lat < WrLat || lat > WrLat + RandMax) begin
      bad++; $display("FAIL decoupled_latency: got %0d want %0d..%0d", lat, WrLat, WrLat + RandMax);
    end
    tot++;
    if (bus.bresp !== eb) begin bad++; $display("FAIL decoupled_bresp: got %h want %h", bus.bresp, eb); end
    cyc();
    rq.push_back('{data: model_read(32'h8000_0030), resp: RESP_OKAY});
    do_read(32'h8000_0030, data, resp, lat);
    e = rq.pop_front();
    tot++;
    if ({data, resp} !== {e.data, e.resp}) begin
      bad++; $display("FAIL decoupled_read: got %h/%h want %h/%h", data, resp, e.data, e.resp);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] raddrs [4] = '{32'h7FFF_FFFC, 32'h8000_1000, 32'h8000_0000, 32'h8000_0FFC};
    logic [31:0] data;
    logic [1:0]  resp, eb;
    int          lat;
    rexp_t       e;
    foreach (raddrs[i]) begin
      if (i == 1 || i == 3) begin
        // Write just past the window and into the last valid word
        bq.push_back(model_resp(raddrs[i]));
        model_write(raddrs[i], 32'h5A5A_0000 | i, 4'hF);
        do_write(raddrs[i], 32'h5A5A_0000 | i, 4'hF, resp, lat);
        eb = bq.pop_front();
        tot++;
        if (resp !== eb) begin bad++; $display("FAIL oor_bresp[%0d]: got %h want %h", i, resp, eb); end
      end
      rq.push_back('{data: model_read(raddrs[i]), resp: model_resp(raddrs[i])});
      do_read(raddrs[i], data, resp, lat);
      e = rq.pop_front();
      tot++;
      if ({data, resp} !== {e.data, e.resp}) begin
        bad++; $display("FAIL oor_read[%0d]: got %h/%h want %h/%h", i, data, resp, e.data, e.resp);
      end
    end
  endtask

  task automatic test_backpressure();
    int    n;
    rexp_t e;
    bus.rready  = 1'b0;
    bus.araddr  = 32'h8000_0010;
    bus.arvalid = 1'b1;
    rq.push_back('{data: model_read(32'h8000_0010), resp: RESP_OKAY});
    n = 0;
    while (!bus.arready && n < 50) begin cyc(); n++; end
    cyc();
    bus.araddr = 32'h8000_0020;  // held valid but must not be accepted
    n = 0;
    while (!bus.rvalid && n < 50) begin cyc(); n++; end
    e = rq.pop_front();
    for (int i = 0; i < 5; i++) begin
      tot++;
      if ({bus.rvalid, bus.arready, bus.rdata, bus.rresp} !== {2'b10, e.data, e.resp}) begin
        bad++;
        $display("FAIL backpressure_hold[%0d]: got %b/%b/%h want 1/0/%h", i, bus.rvalid,
                 bus.arready, bus.rdata, e.data);
      end
      cyc();
    end
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    cyc();
    tot++;
    if ({bus.rvalid, bus.arready} !== 2'b01) begin
      bad++; $display("FAIL backpressure_release: got rvalid/arready=%b want 01", {bus.rvalid, bus.arready});
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] data;
    logic [1:0]  resp;
    int          lat;
    rexp_t       e;
    bus.awaddr  = 32'h8000_0010;
    bus.awvalid = 1'b1;
    bus.wdata   = 32'h0BAD_0BAD;
    bus.wstrb   = 4'hF;
    bus.wvalid  = 1'b1;
    cyc();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    tot++;
    if ({bus.bvalid, bus.rvalid, bus.arready, bus.awready, bus.wready} !== 5'b00111) begin
      bad++;
      $display("FAIL reset_mid_write: got bvalid/rvalid/ar/aw/w=%b want 00111",
               {bus.bvalid, bus.rvalid, bus.arready, bus.awready, bus.wready});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    rq.push_back('{data: model_read(32'h8000_0010), resp: RESP_OKAY});
    do_read(32'h8000_0010, data, resp, lat);
    e = rq.pop_front();
    tot++;
    if ({data, resp} !== {e.data, e.resp}) begin
      bad++; $display("FAIL aborted_write_mem: got %h/%h want %h/%h", data, resp, e.data, e.resp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4] = '{32'h8000_0010, 32'h8000_0020, 32'h8000_0030, 32'h8000_0000};
    int    hs_cyc [$];
    int    issued, got, gap;
    bit    hs;
    rexp_t e;
    bus.rready  = 1'b1;
    bus.araddr  = addrs[0];
    bus.arvalid = 1'b1;
    rq.push_back('{data: model_read(addrs[0]), resp: RESP_OKAY});
    issued = 0;
    got    = 0;
    for (int c = 0; c < 80 && got < 4; c++) begin
      if (bus.rvalid && rq.size() > 0) begin
        e = rq.pop_front();
        got++;
        tot++;
        if ({bus.rdata, bus.rresp} !== {e.data, e.resp}) begin
          bad++; $display("FAIL b2b_data[%0d]: got %h want %h", got, bus.rdata, e.data);
        end
      end
      hs = bus.arvalid && bus.arready;
      cyc();
      if (hs) begin
        hs_cyc.push_back(c);
        issued++;
        if (issued < 4) begin
          bus.araddr = addrs[issued];
          rq.push_back('{data: model_read(addrs[issued]), resp: RESP_OKAY});
        end else begin
          bus.arvalid = 1'b0;
        end
      end
    end
    bus.arvalid = 1'b0;
    tot++;
    if (got !== 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", got); end
    for (int i = 1; i < hs_cyc.size(); i++) begin
      gap = hs_cyc[i] - hs_cyc[i-1];
      tot++;
      if (gap < RdLat + 1 || gap > RdLat + 1 + RandMax) begin
        bad++; $display("FAIL b2b_interval[%0d]: got %0d want %0d..%0d", i, gap, RdLat + 1, RdLat + 1 + RandMax);
      end
    end
    cyc();
  endtask

`ifdef SRAM_RAND_DELAY_EN
  task automatic test_rand_delay();
    logic [31:0] a, data;
    logic [1:0]  resp;
    int          lat, lmin, lmax;
    rexp_t       e;
    lmin = 100;
    lmax = -1;
    for (int i = 0; i < 100; i++) begin
      a = Base + 32'(4 * $urandom_range(0, 3) * 4);
      rq.push_back('{data: model_read(a), resp: RESP_OKAY});
      do_read(a, data, resp, lat);
      e = rq.pop_front();
      tot++;
      if ({data, resp} !== {e.data, e.resp}) begin
        bad++; $display("FAIL rand_data[%0d]: got %h want %h", i, data, e.data);
      end
      tot++;
      if (lat < RdLat || lat > RdLat + 7) begin
        bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d..%0d", i, lat, RdLat, RdLat + 7);
      end
      if (lat < lmin) lmin = lat;
      if (lat > lmax) lmax = lat;
    end
    tot++;
    if (lmin == lmax) begin
      bad++; $display("FAIL rand_spread: got single latency %0d want variation", lmin);
    end
  endtask
`endif

  initial begin
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    test_reset();
    test_write_read();
    test_strobes();
    test_decoupled();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_write();
    test_back_to_back();
`ifdef SRAM_RAND_DELAY_EN
    test_rand_delay();
`endif
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", tot, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
